// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mult_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 4;
  localparam int WIDTH_MAX = 32;

  // Step counter must hold 0..WIDTH-1 with one bit of headroom.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction
endpackage

// File: rtl/add_shift_step.sv
// One multiplier-bit iteration: conditional add (or subtract on the signed
// MSB step) into the WIDTH+1 bit partial sum, then a one-bit right shift.
module add_shift_step import mult_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] a,
  input  logic             is_signed,
  input  logic             last,
  output logic [WIDTH:0]   hi_next,
  output logic [WIDTH-1:0] lo_next
);
  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] sum;
  logic           fill;

  always_comb begin
    a_ext = {is_signed & a[WIDTH-1], a};
    if (!lo[0]) begin
      sum = hi;
    end else if (is_signed && last) begin
      // The multiplier MSB carries weight -2^(WIDTH-1) in two's complement.
      sum = hi - a_ext;
    end else begin
      sum = hi + a_ext;
    end
    fill    = is_signed & sum[WIDTH];
    hi_next = {fill, sum[WIDTH:1]};
    lo_next = {sum[0], lo[WIDTH-1:1]};
  end
endmodule

// File: rtl/shift_add_mult.sv
// Sequential WIDTH x WIDTH multiplier: one multiplier bit per cycle, result
// WIDTH edges after acceptance, held in DONE until the consumer takes it.
module shift_add_mult import mult_pkg::*; #(
  parameter int WIDTH  = 8,
  parameter int PWIDTH = 2 * WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              is_signed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PWIDTH-1:0] product,
  output logic              busy
);
  localparam int            CW        = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic             sign_q;
  logic [WIDTH:0]   acc_hi, hi_next;
  logic [WIDTH-1:0] acc_lo, lo_next;
  logic             accept;
  logic             last;

  add_shift_step #(.WIDTH(WIDTH)) u_step (
    .hi        (acc_hi),
    .lo        (acc_lo),
    .a         (a_q),
    .is_signed (sign_q),
    .last      (last),
    .hi_next   (hi_next),
    .lo_next   (lo_next)
  );

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    last      = (cnt == LAST_STEP);
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        accept   = in_valid;
        if (in_valid) state_nxt = CALC;
      end
      CALC: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Multiplier occupies the low half of the accumulator and is shifted out
  // as product bits shift in, so the final {hi, lo} is the full product.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      a_q     <= '0;
      sign_q  <= 1'b0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      product <= '0;
    end else if (accept) begin
      cnt     <= '0;
      a_q     <= a;
      sign_q  <= is_signed;
      acc_hi  <= '0;
      acc_lo  <= b;
    end else if (state == CALC) begin
      cnt    <= cnt + 1'b1;
      acc_hi <= hi_next;
      acc_lo <= lo_next;
      if (last) product <= PWIDTH'({hi_next[WIDTH-1:0], lo_next});
    end
  end
endmodule

// File: doc/shift_add_mult.md
SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand width in bits, legal range 4..32.
REQ-002 The block SHALL have parameter PWIDTH, default 2*WIDTH, meaning product width; it is derived and SHALL NOT be overridden.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand pair and mode present.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  WIDTH  multiplicand.
REQ-008 b  input  WIDTH  multiplier.
REQ-009 is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with the operands.
REQ-010 out_valid  output  1  product valid.
REQ-011 out_ready  input  1  downstream accepts product.
REQ-012 product  output  PWIDTH  result.
REQ-013 busy  output  1  high in CALC or DONE.

Function
REQ-014 The block SHALL implement three states: IDLE, CALC and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 Acceptance: on an edge with in_valid=1 and in_ready=1, the block SHALL latch a, b and is_signed, clear the accumulator and the step counter, and enter CALC.
REQ-017 in_valid while not in IDLE SHALL be ignored, with no effect on the latched operands.
REQ-018 CALC SHALL process one multiplier bit per cycle, LSB first, as an add-and-shift of the (WIDTH+1)-bit partial sum.
REQ-019 CALC SHALL last exactly WIDTH edges regardless of operand values, including zero operands.
REQ-020 out_valid SHALL rise exactly WIDTH edges after the accepting edge.
REQ-021 Unsigned mode: product SHALL equal a*b, exact in PWIDTH bits.
REQ-022 Signed mode: product SHALL equal the exact two's-complement product in PWIDTH bits.
REQ-023 Signed mode: the final step SHALL subtract a instead of adding when b[WIDTH-1]=1.
REQ-024 Signed mode SHALL give correct results for the most-negative operand in either or both positions.
REQ-025 In DONE, product SHALL hold stable until the handshake completes.
REQ-026 An edge with out_valid=1 and out_ready=1 SHALL return the block to IDLE; out_ready held low SHALL keep the block in DONE indefinitely.
REQ-027 A new operand pair SHALL NOT be accepted on the same edge as the product handshake; throughput is one result per WIDTH+2 cycles minimum.
REQ-028 product SHALL retain the last result while in IDLE until the next acceptance.
REQ-029 busy SHALL be the inverse of in_ready.

Reset
REQ-030 While rst=1 at an edge, state SHALL become IDLE, product, accumulator and counter SHALL become 0, out_valid=0, in_ready=1 and busy=0.
REQ-031 rst SHALL take priority over every handshake; reset mid-CALC or mid-DONE SHALL discard the operation with no out_valid pulse.
REQ-032 An in_valid on the edge that rst deasserts SHALL NOT be accepted; the first acceptance is possible on the following edge.

Structure
REQ-033 Package mult_pkg SHALL hold the state enumeration (IDLE, CALC, DONE) and the WIDTH legal-range constants (WIDTH_MIN=4, WIDTH_MAX=32).
REQ-034 The per-cycle add/subtract-and-shift datapath SHALL be one sub-module, add_shift_step, parametrised by WIDTH, purely combinational.
REQ-035 The FSM, counter and registers SHALL reside in shift_add_mult.
REQ-036 The counter width SHALL be clog2(WIDTH)+1.

Verification (WIDTH=8)
REQ-037 Unsigned case: a=0xFF, b=0xFF, is_signed=0 -> product=0xFE01 and out_valid exactly 8 edges after acceptance.
REQ-038 Signed case: a=0x80, b=0x80, is_signed=1 -> product=0x4000; a=0xFF, b=0x01 -> 0xFFFF; a=0x80, b=0x7F -> 0xC080.
REQ-039 Backpressure: out_ready=0 for 5 cycles after out_valid -> product stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge.
REQ-040 Reset mid-CALC: rst asserted at edge 3 of CALC -> out_valid never asserts, product=0, in_ready=1 after the reset edge; next operation (a=3, b=5) -> product=0x000F.
REQ-041 Back-to-back: in_valid held high with 20 random pairs in both modes, out_ready=1 -> each product matches the reference model and spacing is 10 cycles.
REQ-042 Parameter sweep: WIDTH=4 and WIDTH=32 with extreme operands (0, max, most negative) -> exact products and latency equal to WIDTH.
